// File: rtl/imem_boot_loader_pkg.sv
// boot_pkg: loader state encoding and imem word geometry shared by imem_boot_loader files
package boot_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RELEASE, RUN, ERROR} state_t;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: valid/ready word stream from the boot source into the loader
interface imem_boot_loader_if #(parameter int DATA_W = 32);
  logic s_valid;
  logic s_ready;
  logic s_last;
  logic [DATA_W-1:0] s_data;
  modport master(output s_valid, s_data, s_last, input s_ready);
  modport slave(input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/boot_checksum_acc.sv
// boot_checksum_acc: running mod-2^DATA_W sum of image words, compared with the trailing checksum beat
module boot_checksum_acc #(parameter int DATA_W = 32) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              add_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic [DATA_W-1:0] cmp_i,
  output logic              match_o
);
  logic [DATA_W-1:0] sum_q, sum_d;
  // Clear when a load starts, accumulate every accepted image word
  always_comb sum_d = clr_i ? '0 : add_i ? sum_q + din_i : sum_q;
  // Sum register
  always_ff @(posedge clk) sum_q <= rst ? '0 : sum_d;
  assign match_o = sum_q == cmp_i;
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams an image into imem, then releases the cpu; LOADER_CHECKSUM_EN adds a checksum beat
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int               DATA_W      = 32,
  parameter int               ADDR_W      = 32,
  parameter int               DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int               RELEASE_DLY = 2,
  localparam int              CW          = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.slave   s,
  output logic                initialize,
  output logic [DATA_W-1:0]   instruction_initialize_data,
  output logic [ADDR_W-1:0]   instruction_initialize_address,
  output logic                cpu_rst,
  output logic                done,
  output logic                err,
  output logic [CW-1:0]       word_count
);
  localparam int DLW = $clog2(RELEASE_DLY + 1);
  localparam logic [DLW-1:0] DLY_INIT = DLW'(RELEASE_DLY - 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t AFTER_LAST = CHECK;
`else
  localparam state_t AFTER_LAST = RELEASE;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DLW-1:0] dly_q, dly_d;
  logic s_ready_q, s_ready_d, init_q, init_d, cpu_rst_q, cpu_rst_d, done_q, done_d, err_q, err_d;
  logic beat, sum_ok;
  assign beat = s.s_valid && s_ready_q;
`ifdef LOADER_CHECKSUM_EN
  boot_checksum_acc #(.DATA_W(DATA_W)) u_sum (
    .clk(clk), .rst(rst),
    .clr_i(state_q != LOAD && state_d == LOAD),
    .add_i(state_q == LOAD && beat),
    .din_i(s.s_data), .cmp_i(s.s_data), .match_o(sum_ok)
  );
`else
  assign sum_ok = 1'b1;
`endif
  // Next state, imem write pair and registered outputs, all derived from the upcoming state
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    data_d = data_q;
    addr_d = addr_q;
    dly_d = (state_q == RELEASE) ? dly_q - 1'b1 : DLY_INIT;
    case (state_q)
      IDLE, RUN, ERROR: if (start) begin
        state_d = LOAD;
        cnt_d = '0;
      end
      LOAD: if (beat) begin
        data_d = s.s_data;
        addr_d = BASE_ADDR + ADDR_W'(cnt_q) * ADDR_W'(WORD_BYTES);
        cnt_d = cnt_q + CW'(1);
        state_d = s.s_last ? AFTER_LAST : (cnt_q == CW'(DEPTH - 1)) ? ERROR : LOAD;
      end
      CHECK: if (beat) state_d = sum_ok ? RELEASE : ERROR;
      RELEASE: if (dly_q == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
    s_ready_d = state_d == LOAD || state_d == CHECK;
    init_d = !(state_d == RELEASE || state_d == RUN);
    cpu_rst_d = state_d != RUN;
    done_d = state_d == RUN;
    err_d = state_d == ERROR;
  end
  // State and output registers; the cpu is held from the first reset edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      data_q <= '0;
      addr_q <= BASE_ADDR;
      dly_q <= DLY_INIT;
      s_ready_q <= 1'b0;
      init_q <= 1'b1;
      cpu_rst_q <= 1'b1;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      addr_q <= addr_d;
      dly_q <= dly_d;
      s_ready_q <= s_ready_d;
      init_q <= init_d;
      cpu_rst_q <= cpu_rst_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign s.s_ready = s_ready_q;
  assign initialize = init_q;
  assign instruction_initialize_data = data_q;
  assign instruction_initialize_address = addr_q;
  assign cpu_rst = cpu_rst_q;
  assign done = done_q;
  assign err = err_q;
  assign word_count = cnt_q;
endmodule
